// File: rtl/chip_checker_pkg.sv
// chip_checker_pkg: chip codes, FSM states, socket pin maps and gate truth functions
// Pin indices below are bit positions (pin number - 1).
package chip_checker_pkg;
  typedef enum logic [2:0] {
    CHIP_7400 = 3'd0,
    CHIP_7402 = 3'd1,
    CHIP_7408 = 3'd2,
    CHIP_7432 = 3'd3,
    CHIP_7486 = 3'd4
  } chip_e;
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_COMPARE, S_DONE} state_e;
  localparam logic [13:0] STD_IN_MASK  = 14'h1B1B;
  localparam logic [13:0] STD_OUT_MASK = 14'h04A4;
  localparam logic [13:0] NOR_IN_MASK  = 14'h0DB6;
  localparam logic [13:0] NOR_OUT_MASK = 14'h1209;
  localparam logic [3:0] STD_A [4] = '{4'd0, 4'd3, 4'd9, 4'd12};
  localparam logic [3:0] STD_B [4] = '{4'd1, 4'd4, 4'd8, 4'd11};
  localparam logic [3:0] STD_Y [4] = '{4'd2, 4'd5, 4'd7, 4'd10};
  localparam logic [3:0] NOR_A [4] = '{4'd1, 4'd4, 4'd7, 4'd10};
  localparam logic [3:0] NOR_B [4] = '{4'd2, 4'd5, 4'd8, 4'd11};
  localparam logic [3:0] NOR_Y [4] = '{4'd0, 4'd3, 4'd9, 4'd12};
  function automatic logic expected_out(chip_e c, logic a, logic b);
    expected_out = (c == CHIP_7400) ? ~(a & b) :
                   (c == CHIP_7402) ? ~(a | b) :
                   (c == CHIP_7408) ?  (a & b) :
                   (c == CHIP_7432) ?  (a | b) : (a ^ b);
  endfunction
  function automatic logic [13:0] in_mask(chip_e c);
    in_mask = (c == CHIP_7402) ? NOR_IN_MASK : STD_IN_MASK;
  endfunction
  function automatic logic [13:0] out_mask(chip_e c);
    out_mask = (c == CHIP_7402) ? NOR_OUT_MASK : STD_OUT_MASK;
  endfunction
  function automatic logic [13:0] drive_pins(chip_e c, logic a, logic b);
    drive_pins = '0;
    for (int g = 0; g < 4; g++) begin
      drive_pins[(c == CHIP_7402) ? NOR_A[g] : STD_A[g]] = a;
      drive_pins[(c == CHIP_7402) ? NOR_B[g] : STD_B[g]] = b;
    end
  endfunction
  function automatic logic [3:0] gate_out(chip_e c, logic [13:0] pins);
    for (int g = 0; g < 4; g++) gate_out[g] = pins[(c == CHIP_7402) ? NOR_Y[g] : STD_Y[g]];
  endfunction
endpackage

// File: rtl/chip_test_sequencer_if.sv
// chip_test_sequencer_if: control handshake, result and socket pin bundle
// master = controller/socket side, slave = sequencer.
interface chip_test_sequencer_if;
  logic        start;
  logic [2:0]  chip_sel;
  logic [13:0] pin_in;
  logic [13:0] pin_out;
  logic [13:0] pin_oe;
  logic        busy;
  logic        done;
  logic        pass;
  logic [3:0]  fail_gate;
  logic [1:0]  fail_vec;
  logic        sel_err;
  modport master (output start, chip_sel, pin_in,
                  input pin_out, pin_oe, busy, done, pass, fail_gate, fail_vec, sel_err);
  modport slave  (input start, chip_sel, pin_in,
                  output pin_out, pin_oe, busy, done, pass, fail_gate, fail_vec, sel_err);
endinterface

// File: rtl/chip_test_sequencer_pin_sync.sv
// pin_sync: 14-bit two-flop synchronizer for raw socket pins
// Ports: clk, rst_n (async active-low, clears to 0), d (raw pins), q (synchronized pins).
module pin_sync (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] d,
  output logic [13:0] q
);
  logic [13:0] meta_d, meta_q, sync_d, sync_q;
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  assign q = sync_q;
endmodule

// File: rtl/chip_test_sequencer.sv
// chip_test_sequencer: truth-table test of one quad 2-input gate chip in the 14-pin socket
// Ports: clk, rst_n (async active-low), bus (slave modport: start/chip_sel request,
// pin_in/pin_out/pin_oe socket pins, busy/done/pass/fail_gate/fail_vec/sel_err results).
// Option: define CHK_STOP_ON_FAIL_EN to end the test on the first failing vector.
module chip_test_sequencer
  import chip_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 50
) (
  input logic                  clk,
  input logic                  rst_n,
  chip_test_sequencer_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYCLES);
  state_e        state_d, state_q;
  chip_e         chip_d, chip_q;
  logic [1:0]    v_d, v_q, fail_vec_d, fail_vec_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [3:0]    samp_d, samp_q, fail_gate_d, fail_gate_q, mismatch;
  logic [13:0]   pin_out_d, pin_out_q, pin_oe_d, pin_oe_q, sync_pins;
  logic          pass_d, pass_q, sel_err_d, sel_err_q, done_d, done_q, busy_d, busy_q, last;
  pin_sync u_sync (.clk(clk), .rst_n(rst_n), .d(bus.pin_in), .q(sync_pins));
  assign mismatch = samp_q ^ {4{expected_out(chip_q, v_q[1], v_q[0])}};
`ifdef CHK_STOP_ON_FAIL_EN
  assign last = (v_q == 2'd3) || (|mismatch);
`else
  assign last = v_q == 2'd3;
`endif
  always_comb begin
    state_d     = state_q;
    chip_d      = chip_q;
    v_d         = v_q;
    cnt_d       = cnt_q;
    samp_d      = samp_q;
    fail_gate_d = fail_gate_q;
    fail_vec_d  = fail_vec_q;
    pass_d      = pass_q;
    sel_err_d   = sel_err_q;
    unique case (state_q)
      S_IDLE:
        if (bus.start) begin
          if (bus.chip_sel <= 3'd4) begin
            chip_d      = chip_e'(bus.chip_sel);
            fail_gate_d = '0;
            fail_vec_d  = '0;
            pass_d      = 1'b0;
            sel_err_d   = 1'b0;
            v_d         = '0;
            state_d     = S_APPLY;
          end else begin
            sel_err_d = 1'b1;
            pass_d    = 1'b0;
            state_d   = S_DONE;
          end
        end
      S_APPLY: begin
        cnt_d   = CW'(SETTLE_CYCLES - 1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? S_SAMPLE : S_SETTLE;
      end
      S_SAMPLE: begin
        samp_d  = gate_out(chip_q, sync_pins & out_mask(chip_q));
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        fail_gate_d = fail_gate_q | mismatch;
        fail_vec_d  = (fail_gate_q == '0 && mismatch != '0) ? v_q : fail_vec_q;
        v_d         = last ? v_q : v_q + 1'b1;
        state_d     = last ? S_DONE : S_APPLY;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Pass is resolved on entry to DONE so it is already valid during the Done pulse.
    if (state_d == S_DONE) pass_d = (fail_gate_d == '0) & ~sel_err_d;
    done_d    = state_d == S_DONE;
    busy_d    = state_d inside {S_APPLY, S_SETTLE, S_SAMPLE, S_COMPARE};
    pin_oe_d  = busy_d ? in_mask(chip_d) : '0;
    pin_out_d = !busy_d ? '0 : (state_d == S_APPLY) ? drive_pins(chip_d, v_d[1], v_d[0]) : pin_out_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= S_IDLE;
      chip_q      <= CHIP_7400;
      v_q         <= '0;
      cnt_q       <= '0;
      samp_q      <= '0;
      fail_gate_q <= '0;
      fail_vec_q  <= '0;
      pass_q      <= 1'b0;
      sel_err_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      pin_oe_q    <= '0;
      pin_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      chip_q      <= chip_d;
      v_q         <= v_d;
      cnt_q       <= cnt_d;
      samp_q      <= samp_d;
      fail_gate_q <= fail_gate_d;
      fail_vec_q  <= fail_vec_d;
      pass_q      <= pass_d;
      sel_err_q   <= sel_err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      pin_oe_q    <= pin_oe_d;
      pin_out_q   <= pin_out_d;
    end
  assign bus.pin_out   = pin_out_q;
  assign bus.pin_oe    = pin_oe_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_gate = fail_gate_q;
  assign bus.fail_vec  = fail_vec_q;
  assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_chip_test_sequencer.sv
// tb_chip_test_sequencer: directed bench with a behavioural socket model and fault injection
module tb_chip_test_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;
  chip_test_sequencer_if bus ();
  chip_test_sequencer #(.SETTLE_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  localparam int STD_AP [4] = '{1, 4, 10, 13};
  localparam int STD_BP [4] = '{2, 5, 9, 12};
  localparam int STD_YP [4] = '{3, 6, 8, 11};
  localparam int NOR_AP [4] = '{2, 5, 8, 11};
  localparam int NOR_BP [4] = '{3, 6, 9, 12};
  localparam int NOR_YP [4] = '{1, 4, 10, 13};
  int   m_chip = 0;
  logic f_en = 1'b0;
  int   f_g = 0;
  logic f_v = 1'b0;
  logic [13:0] sock;
  always_comb begin
    sock = '0;
    for (int g = 0; g < 4; g++) begin
      logic a, b, y;
      a = bus.pin_out[((m_chip == 1) ? NOR_AP[g] : STD_AP[g]) - 1] & bus.pin_oe[((m_chip == 1) ? NOR_AP[g] : STD_AP[g]) - 1];
      b = bus.pin_out[((m_chip == 1) ? NOR_BP[g] : STD_BP[g]) - 1] & bus.pin_oe[((m_chip == 1) ? NOR_BP[g] : STD_BP[g]) - 1];
      case (m_chip)
        0:       y = ~(a & b);
        1:       y = ~(a | b);
        2:       y = a & b;
        3:       y = a | b;
        default: y = a ^ b;
      endcase
      if (f_en && g == f_g) y = f_v;
      sock[((m_chip == 1) ? NOR_YP[g] : STD_YP[g]) - 1] = y;
    end
  end
  assign bus.pin_in = sock;
  int n_chk = 0;
  int n_fail = 0;
  int done_at, done_cnt;
  logic oe_bad, busy_seen;
  logic [13:0] po10, po25;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [2:0] sel, input int win, input int again_at, input logic [13:0] exp_oe);
    done_at = 0;
    done_cnt = 0;
    oe_bad = 1'b0;
    busy_seen = 1'b0;
    po10 = '0;
    po25 = '0;
    bus.chip_sel = sel;
    bus.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= win; n++) begin
      @(negedge clk);
      bus.start = (n == again_at);
      if (n == 2) bus.chip_sel = 3'd4;
      if (bus.done) begin
        if (done_cnt == 0) done_at = n;
        done_cnt++;
      end
      if (bus.busy) busy_seen = 1'b1;
      if (bus.pin_oe !== (bus.busy ? exp_oe : 14'h0)) oe_bad = 1'b1;
      if (n == 10) po10 = bus.pin_out;
      if (n == 25) po25 = bus.pin_out;
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.chip_sel = '0;
    repeat (2) @(negedge clk);
    check("rst_pin_oe", 32'(bus.pin_oe), 0);
    check("rst_pin_out", 32'(bus.pin_out), 0);
    check("rst_flags", {bus.busy, bus.done, bus.pass, bus.sel_err}, 0);
    check("rst_fail", {bus.fail_gate, bus.fail_vec}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    m_chip = 0;
    run(3'd0, 40, 0, 14'h1B1B);
    check("7400_done_at", done_at, 29);
    check("7400_done_cnt", done_cnt, 1);
    check("7400_oe", 32'(oe_bad), 0);
    check("7400_po_v1", 32'(po10), 32'h0912);
    check("7400_po_v3", 32'(po25), 32'h1B1B);
    check("7400_pass", {bus.pass, bus.sel_err, bus.fail_gate}, 32'h20);
    check("7400_pinout_idle", 32'(bus.pin_out), 0);
    m_chip = 1;
    run(3'd1, 40, 0, 14'h0DB6);
    check("7402_done_at", done_at, 29);
    check("7402_oe", 32'(oe_bad), 0);
    check("7402_po_v1", 32'(po10), 32'h0924);
    check("7402_po_v3", 32'(po25), 32'h0DB6);
    check("7402_pass", {bus.pass, bus.fail_gate}, 32'h10);
    m_chip = 2; f_en = 1'b1; f_g = 2; f_v = 1'b0;
    run(3'd2, 40, 0, 14'h1B1B);
    check("7408_done_at", done_at, 29);
    check("7408_fail_gate", 32'(bus.fail_gate), 32'b0100);
    check("7408_fail_vec", 32'(bus.fail_vec), 32'b11);
    check("7408_pass", 32'(bus.pass), 0);
    m_chip = 4; f_g = 0; f_v = 1'b1;
    run(3'd4, 40, 0, 14'h1B1B);
`ifdef CHK_STOP_ON_FAIL_EN
    check("7486_done_at", done_at, 8);
`else
    check("7486_done_at", done_at, 29);
`endif
    check("7486_fail_gate", 32'(bus.fail_gate), 32'b0001);
    check("7486_fail_vec", 32'(bus.fail_vec), 0);
    check("7486_pass", 32'(bus.pass), 0);
    f_en = 1'b0;
    run(3'd6, 10, 0, 14'h0);
    check("inv_done_at", done_at, 1);
    check("inv_done_cnt", done_cnt, 1);
    check("inv_no_busy", {busy_seen, oe_bad}, 0);
    check("inv_flags", {bus.sel_err, bus.pass}, 32'b10);
    m_chip = 3;
    run(3'd3, 40, 0, 14'h1B1B);
    check("7432_done_at", done_at, 29);
    check("7432_clear", {bus.pass, bus.sel_err, bus.fail_gate, bus.fail_vec}, 32'h80);
    m_chip = 0;
    run(3'd0, 60, 5, 14'h1B1B);
    check("restart_done_cnt", done_cnt, 1);
    check("restart_done_at", done_at, 29);
    check("restart_pass", 32'(bus.pass), 1);
    bus.chip_sel = 3'd0;
    bus.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("mid_oe_before", 32'(bus.pin_oe), 32'h1B1B);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", 32'(bus.pin_oe), 0);
    check("mid_rst_busy", {bus.busy, bus.done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_idle", {bus.busy, 18'(bus.pin_oe)}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
